switch_allocator: RTL and testbench



---
 rtl/params_noc.sv | 12 +
 rtl/switch_allocator_if.sv | 26 ++
 rtl/switch_allocator.sv | 131 +++++++++++++
 tb/tb_switch_allocator.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_noc.sv
// Shared NoC router types: port enumeration used by route computation and allocation.
package params_noc;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } inout_Port;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant/crossbar bundle between input buffers, switch allocator and crossbar.
interface switch_allocator_if #(
    parameter int unsigned NUM_PORTS = 5
);
    localparam int unsigned SW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]                  req_valid_i;
    params_noc::inout_Port [NUM_PORTS-1:0] req_port_i;
    logic [NUM_PORTS-1:0]                  req_head_i;
    logic [NUM_PORTS-1:0]                  req_tail_i;
    logic [NUM_PORTS-1:0]                  credit_inc_i;
    logic [NUM_PORTS-1:0]                  grant_o;
    logic [NUM_PORTS-1:0]                  xbar_valid_o;
    logic [NUM_PORTS-1:0][SW-1:0]          xbar_sel_o;

    modport master (
        output req_valid_i, req_port_i, req_head_i, req_tail_i, credit_inc_i,
        input  grant_o, xbar_valid_o, xbar_sel_o
    );

    modport slave (
        input  req_valid_i, req_port_i, req_head_i, req_tail_i, credit_inc_i,
        output grant_o, xbar_valid_o, xbar_sel_o
    );

endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking and credit flow control;
// grants are combinational, crossbar selects are the registered copy of each allocation.
module switch_allocator #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned BUF_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave bus
);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = $clog2(NUM_PORTS);
    localparam int unsigned PW = $bits(params_noc::inout_Port);

    logic [NUM_PORTS-1:0]         lock_valid_q;
    logic [NUM_PORTS-1:0][SW-1:0] lock_owner_q;
    logic [NUM_PORTS-1:0][SW-1:0] rr_ptr_q;
    logic [NUM_PORTS-1:0][CW-1:0] credit_q;
    logic [NUM_PORTS-1:0]         xbar_valid_q;
    logic [NUM_PORTS-1:0][SW-1:0] xbar_sel_q;

    // Request matrices indexed [output][input].
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_to;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] head_to;

    logic [NUM_PORTS-1:0]         out_gnt;
    logic [NUM_PORTS-1:0][SW-1:0] out_idx;
    logic [NUM_PORTS-1:0]         out_tail;
    logic [NUM_PORTS-1:0]         in_gnt;

    always_comb begin : decode
        req_to  = '0;
        head_to = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                req_to[o][i]  = bus.req_valid_i[i] && (bus.req_port_i[i] == PW'(o));
                head_to[o][i] = req_to[o][i] && bus.req_head_i[i];
            end
        end
    end

    always_comb begin : allocate
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        out_gnt  = '0;
        out_idx  = '0;
        out_tail = '0;
        in_gnt   = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            found = 1'b0;
            if (credit_q[o] != '0) begin
                if (lock_valid_q[o]) begin
                    // Only the owning input may continue; its flit type is irrelevant.
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        if (lock_owner_q[o] == SW'(i) && req_to[o][i]) begin
                            out_gnt[o]  = 1'b1;
                            out_idx[o]  = SW'(i);
                            out_tail[o] = bus.req_tail_i[i];
                        end
                    end
                end else begin
                    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
                        idx = 32'(rr_ptr_q[o]) + off;
                        if (idx >= NUM_PORTS) begin
                            idx = idx - NUM_PORTS;
                        end
                        if (!found && head_to[o][idx]) begin
                            found       = 1'b1;
                            out_gnt[o]  = 1'b1;
                            out_idx[o]  = SW'(idx);
                            out_tail[o] = bus.req_tail_i[idx];
                        end
                    end
                end
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (out_gnt[o] && out_idx[o] == SW'(i)) begin
                    in_gnt[i] = 1'b1;
                end
            end
        end
    end

    assign bus.grant_o      = rst ? '0 : in_gnt;
    assign bus.xbar_valid_o = xbar_valid_q;
    assign bus.xbar_sel_o   = xbar_sel_q;

    always_ff @(posedge clk or posedge rst) begin : state_regs
        if (rst) begin
            lock_valid_q <= '0;
            lock_owner_q <= '0;
            rr_ptr_q     <= '0;
            xbar_valid_q <= '0;
            xbar_sel_q   <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                credit_q[o] <= CW'(BUF_DEPTH);
            end
        end else begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                xbar_valid_q[o] <= out_gnt[o];
                if (out_gnt[o]) begin
                    xbar_sel_q[o] <= out_idx[o];
                    if (lock_valid_q[o]) begin
                        if (out_tail[o]) begin
                            lock_valid_q[o] <= 1'b0;
                        end
                    end else begin
                        rr_ptr_q[o] <= (out_idx[o] == SW'(NUM_PORTS - 1)) ? '0
                                                                         : out_idx[o] + SW'(1);
                        if (!out_tail[o]) begin
                            lock_valid_q[o] <= 1'b1;
                            lock_owner_q[o] <= out_idx[o];
                        end
                    end
                end
                // A grant and a returned credit in the same cycle cancel out.
                if (out_gnt[o] && !bus.credit_inc_i[o]) begin
                    credit_q[o] <= credit_q[o] - CW'(1);
                end else if (!out_gnt[o] && bus.credit_inc_i[o] &&
                             credit_q[o] != CW'(BUF_DEPTH)) begin
                    credit_q[o] <= credit_q[o] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus randomized traffic
// compared against a per-output packet-level reference model.
module tb_switch_allocator;
    import params_noc::*;

    localparam int NP = 5;
    localparam int BD = 4;

    logic clk;
    logic rst;

    switch_allocator_if #(.NUM_PORTS(NP)) bus ();

    switch_allocator #(.NUM_PORTS(NP), .BUF_DEPTH(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state.
    int              m_credit [NP];
    int              m_lock   [NP];
    int              m_rr     [NP];
    logic [NP-1:0]   m_xv;
    logic [NP-1:0][2:0] m_xs;

    logic [NP-1:0]      exp_grant;
    logic [NP-1:0]      obs_grant;
    logic [NP-1:0]      obs_xv;
    logic [NP-1:0][2:0] obs_xs;

    function automatic void model_reset();
        for (int o = 0; o < NP; o++) begin
            m_credit[o] = BD;
            m_lock[o]   = -1;
            m_rr[o]     = 0;
        end
        m_xv = '0;
        m_xs = '0;
    endfunction

    function automatic logic [NP-1:0] model_alloc(output int w[NP]);
        logic [NP-1:0] g;
        g = '0;
        for (int o = 0; o < NP; o++) begin
            w[o] = -1;
            if (m_credit[o] > 0) begin
                if (m_lock[o] >= 0) begin
                    if (bus.req_valid_i[m_lock[o]] && int'(bus.req_port_i[m_lock[o]]) == o)
                        w[o] = m_lock[o];
                end else begin
                    for (int d = 0; d < NP; d++) begin
                        int i;
                        i = (m_rr[o] + d) % NP;
                        if (w[o] < 0 && bus.req_valid_i[i] && bus.req_head_i[i] &&
                            int'(bus.req_port_i[i]) == o)
                            w[o] = i;
                    end
                end
            end
            if (w[o] >= 0) g[w[o]] = 1'b1;
        end
        return g;
    endfunction

    function automatic void model_commit(input int w[NP]);
        for (int o = 0; o < NP; o++) begin
            if (w[o] >= 0) begin
                if (m_lock[o] >= 0) begin
                    if (bus.req_tail_i[w[o]]) m_lock[o] = -1;
                end else begin
                    m_rr[o] = (w[o] + 1) % NP;
                    if (!bus.req_tail_i[w[o]]) m_lock[o] = w[o];
                end
                m_xv[o] = 1'b1;
                m_xs[o] = 3'(w[o]);
            end else begin
                m_xv[o] = 1'b0;
            end
            if (w[o] >= 0 && !bus.credit_inc_i[o]) m_credit[o] = m_credit[o] - 1;
            else if (w[o] < 0 && bus.credit_inc_i[o] && m_credit[o] < BD) m_credit[o] = m_credit[o] + 1;
        end
    endfunction

    task automatic clear_inputs();
        bus.req_valid_i  = '0;
        bus.req_head_i   = '0;
        bus.req_tail_i   = '0;
        bus.credit_inc_i = '0;
        for (int i = 0; i < NP; i++) bus.req_port_i[i] = LOCAL;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: sample grant mid-cycle, advance model at the edge, sample crossbar after it.
    task automatic apply();
        int w[NP];
        @(negedge clk);
        exp_grant = model_alloc(w);
        obs_grant = bus.grant_o;
        @(posedge clk);
        model_commit(w);
        #1;
        obs_xv = bus.xbar_valid_o;
        obs_xs = bus.xbar_sel_o;
    endtask

    task automatic set_req(input int i, input inout_Port p, input logic h, input logic t);
        bus.req_valid_i[i] = 1'b1;
        bus.req_port_i[i]  = p;
        bus.req_head_i[i]  = h;
        bus.req_tail_i[i]  = t;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        clear_inputs();
        set_req(0, EAST, 1'b1, 1'b1);
        #3;
        vectors++;
        if (bus.grant_o !== '0) begin
            miscompares++;
            $display("FAIL reset_grant_forced: got %b expected %b", bus.grant_o, 5'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_inputs();
        vectors++;
        if (bus.xbar_valid_o !== '0 || bus.xbar_sel_o !== '0) begin
            miscompares++;
            $display("FAIL reset_xbar: got valid %b sel %h expected 0", bus.xbar_valid_o, bus.xbar_sel_o);
        end
        apply();
        vectors++;
        if (obs_grant !== '0 || obs_xv !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got grant %b xv %b expected 0", obs_grant, obs_xv);
        end
        // Returning a credit at full must not raise the count above BUF_DEPTH.
        bus.credit_inc_i = '1;
        apply();
        clear_inputs();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            set_req(0, WEST, 1'b1, 1'b1);
            apply();
            if (obs_grant[0]) cnt++;
        end
        vectors++;
        if (cnt !== BD) begin
            miscompares++;
            $display("FAIL credit_saturation: got %0d grants expected %0d", cnt, BD);
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_req(0, EAST, 1'b1, 1'b1);
            set_req(1, EAST, 1'b1, 1'b1);
            set_req(2, EAST, 1'b1, 1'b1);
            bus.credit_inc_i[EAST] = 1'b1;
            apply();
            e = NP'(1) << (k % 3);
            vectors++;
            if (obs_grant !== e) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, obs_grant, e);
            end
            vectors++;
            if (obs_xv[EAST] !== 1'b1 || obs_xs[EAST] !== 3'(k % 3)) begin
                miscompares++;
                $display("FAIL rr_xbar[%0d]: got valid %b sel %0d expected 1 %0d",
                         k, obs_xv[EAST], obs_xs[EAST], k % 3);
            end
        end
    endtask

    task automatic test_wormhole();
        logic [NP-1:0] e;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            if (k < 4) set_req(1, NORTH, k == 0, k == 3);
            set_req(3, NORTH, 1'b1, 1'b1);
            bus.credit_inc_i[NORTH] = 1'b1;
            apply();
            e = (k < 4) ? NP'(2) : NP'(8);
            vectors++;
            if (obs_grant !== e) begin
                miscompares++;
                $display("FAIL wormhole_grant[%0d]: got %b expected %b", k, obs_grant, e);
            end
            vectors++;
            if (obs_xv[NORTH] !== 1'b1 || obs_xs[NORTH] !== ((k < 4) ? 3'd1 : 3'd3)) begin
                miscompares++;
                $display("FAIL wormhole_xbar[%0d]: got valid %b sel %0d", k, obs_xv[NORTH], obs_xs[NORTH]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_credit_exhaust();
        int f;
        int cnt;
        logic [NP-1:0] e;
        do_reset();
        f = 0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (f < 6) set_req(0, WEST, f == 0, f == 5);
            if (c >= 7) set_req(2, WEST, 1'b1, 1'b1);
            bus.credit_inc_i[WEST] = (c == 6 || c == 8);
            apply();
            e = (c < 4 || c == 7 || c == 9) ? NP'(1) : NP'(0);
            vectors++;
            if (obs_grant !== e) begin
                miscompares++;
                $display("FAIL credit_exhaust[%0d]: got %b expected %b", c, obs_grant, e);
            end
            if (obs_grant[0]) begin
                f++;
                cnt++;
            end
        end
        vectors++;
        if (cnt !== 6) begin
            miscompares++;
            $display("FAIL credit_exhaust_total: got %0d expected 6", cnt);
        end
        clear_inputs();
    endtask

    task automatic test_grant_and_inc();
        logic [NP-1:0] e;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            set_req(0, SOUTH, 1'b1, 1'b1);
            bus.credit_inc_i[SOUTH] = (c == 3);
            apply();
            e = (c < 5) ? NP'(1) : NP'(0);
            vectors++;
            if (obs_grant !== e) begin
                miscompares++;
                $display("FAIL grant_and_inc[%0d]: got %b expected %b", c, obs_grant, e);
            end
        end
        clear_inputs();
    endtask

    task automatic test_bubble_reset();
        logic [NP-1:0] e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0 || c == 4) set_req(2, SOUTH, c == 0, 1'b0);
            if (c > 0) set_req(4, SOUTH, 1'b1, 1'b0);
            bus.credit_inc_i[SOUTH] = 1'b1;
            apply();
            e = (c == 0 || c == 4) ? NP'(4) : NP'(0);
            vectors++;
            if (obs_grant !== e) begin
                miscompares++;
                $display("FAIL bubble[%0d]: got %b expected %b", c, obs_grant, e);
            end
        end
        do_reset();
        set_req(2, SOUTH, 1'b0, 1'b0);
        set_req(4, SOUTH, 1'b1, 1'b0);
        apply();
        vectors++;
        if (obs_grant !== NP'(16)) begin
            miscompares++;
            $display("FAIL reset_mid_packet: got %b expected %b", obs_grant, NP'(16));
        end
        vectors++;
        if (obs_xv[SOUTH] !== 1'b1 || obs_xs[SOUTH] !== 3'd4) begin
            miscompares++;
            $display("FAIL reset_mid_packet_xbar: got valid %b sel %0d expected 1 4",
                     obs_xv[SOUTH], obs_xs[SOUTH]);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                bus.req_valid_i[i] = ($urandom_range(0, 3) != 0);
                bus.req_port_i[i]  = inout_Port'(3'($urandom_range(0, 4)));
                bus.req_head_i[i]  = ($urandom_range(0, 2) == 0);
                bus.req_tail_i[i]  = ($urandom_range(0, 2) == 0);
                bus.credit_inc_i[i] = ($urandom_range(0, 1) == 0);
            end
            apply();
            vectors++;
            if (obs_grant !== exp_grant) begin
                miscompares++;
                $display("FAIL random_grant[%0d]: got %b expected %b", c, obs_grant, exp_grant);
            end
            vectors++;
            if (obs_xv !== m_xv) begin
                miscompares++;
                $display("FAIL random_xv[%0d]: got %b expected %b", c, obs_xv, m_xv);
            end
            vectors++;
            if (obs_xs !== m_xs) begin
                miscompares++;
                $display("FAIL random_xs[%0d]: got %h expected %h", c, obs_xs, m_xs);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_grant_and_inc();
        test_bubble_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
